// File: rtl/ncl_sample_rx.sv
// Dual-rail (NULL/DATA) sample receiver: synchronises both rails, completion-detects each
// wavefront, drives ko and queues words in a fall-through FIFO. Optional check: NCL_RX_ERRCHK_EN.
module ncl_sample_rx #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_t,
   input  logic [WIDTH-1:0]         in_f,
   output logic                     ko,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   typedef enum logic {
      WAIT_NULL = 1'b0,
      WAIT_DATA = 1'b1
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [WIDTH-1:0] r_s1t, r_s1f, r_s2t, r_s2f, r_s3t, r_s3f;
   logic [2:0]       r_primed;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr, r_rdPtr;
   logic [AW:0]      r_count;

   logic w_complete, w_isNull, w_stable, w_push, w_pop;

   // r_primed marks s3 as holding real samples, so the cleared pipeline is not mistaken for NULL.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1t    <= '0;
         r_s1f    <= '0;
         r_s2t    <= '0;
         r_s2f    <= '0;
         r_s3t    <= '0;
         r_s3f    <= '0;
         r_primed <= '0;
      end else begin
         r_s1t    <= in_t;
         r_s1f    <= in_f;
         r_s2t    <= r_s1t;
         r_s2f    <= r_s1f;
         r_s3t    <= r_s2t;
         r_s3f    <= r_s2f;
         r_primed <= {r_primed[1:0], 1'b1};
      end
   end

   assign w_complete = &(r_s2t ^ r_s2f);
   assign w_isNull   = ~|(r_s2t | r_s2f);
   assign w_stable   = r_primed[2] && (r_s2t == r_s3t) && (r_s2f == r_s3f);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= WAIT_NULL;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Leaving WAIT_NULL is only allowed with a free slot, so a push can never hit a full FIFO.
   always_comb begin
      w_nextState = r_state;
      w_push      = 1'b0;
      case (r_state)
         WAIT_NULL: begin
            if (w_isNull && w_stable && (r_count != FULL_COUNT)) begin
               w_nextState = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (w_complete && w_stable) begin
               w_push      = 1'b1;
               w_nextState = WAIT_NULL;
            end
         end
         default: w_nextState = WAIT_NULL;
      endcase
   end

   assign ko    = (r_state == WAIT_DATA);
   assign w_pop = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= r_s2t;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign count     = r_count;
   assign out_valid = (r_count != '0);
   assign out_data  = out_valid ? r_mem[r_rdPtr] : '0;

`ifdef NCL_RX_ERRCHK_EN
   logic r_err;

   // A settled both-rails-high bit is an illegal code; the flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if ((|(r_s2t & r_s2f)) && w_stable) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule
